uart_driver: RTL
================

# uart_driver

Simulation-side UART transmitter that drives the SoC `serial_rx` input on the DE0-Nano bench. It complements the receive-only `uart_monitor`. Bytes pushed by the bench over a valid/ready handshake are buffered in a FIFO and serialised as 8N1 frames at the configured baud rate. It is written as synthesizable RTL so it can also be reused as an on-board stimulus source.

## Interface
Parameters:
- `CLK_FREQUENCY`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 16: byte buffer depth; must be a power of two and at least 2.

Ports:
- `clk`, in, 1: sole clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: FIFO can accept a byte.
- `uart_tx`, out, 1: serial line, idle high; connects to the SoC `serial_rx`.
- `busy`, out, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: bytes currently buffered.

## Operation
- `CLKS_PER_BIT` = `CLK_FREQUENCY / BAUD_RATE`, using integer truncation. The default is 434.
  - Elaboration fails (`$error`) if `CLKS_PER_BIT` < 2.
- Frame format: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). A frame is 10 × `CLKS_PER_BIT` cycles.
- Handshake:
  - A byte is accepted on any edge where `tx_valid && tx_ready`.
  - `tx_ready = (fifo_count != FIFO_DEPTH)`, combinational.
  - `tx_valid` while `tx_ready` is low is ignored. There is no push-through when full.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: when the FIFO is non-empty. Pop the head into the shift register and drive `uart_tx`=0.
  - START → DATA: after `CLKS_PER_BIT` cycles. Drive bit 0.
  - DATA: every `CLKS_PER_BIT` cycles, shift right and increment the bit index (0..7). After bit 7 completes, go to STOP and drive `uart_tx`=1.
  - STOP → START: after `CLKS_PER_BIT` cycles, if the FIFO is non-empty. Pop immediately, leaving zero idle cycles between frames.
  - STOP → IDLE: otherwise.
- Push and pop on the same edge: both take effect, so `fifo_count` is unchanged.
- `fifo_count` wraps nowhere: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo the depth, and the count is derived independently.
- `busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing
- Reset values: `uart_tx`=1, `fifo_count`=0, `busy`=0, `tx_ready`=1, state=IDLE, baud counter=0, bit index=0.
- Pushes on the reset edge are discarded.
- Reset mid-frame aborts the frame:
  - `uart_tx` is 1 after the reset edge.
  - The FIFO is flushed.
  - No partial frame resumes.
- Latency: a byte accepted at edge E0 into an empty FIFO with the FSM in IDLE makes `uart_tx` fall at edge E1. `fifo_count` shows 1 after E0 and 0 after E1.
- `uart_tx` is driven from a flop, so it is glitch-free.
- Each bit holds exactly `CLKS_PER_BIT` cycles. The baud counter reloads on every state or bit transition.
- Sustained throughput is one byte per 10 × `CLKS_PER_BIT` cycles.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum (IDLE/START/DATA/STOP).
  - `localparam` frame constants: `DATA_BITS`=8, `STOP_LEVEL`=1'b1, `IDLE_LEVEL`=1'b1.
  - Function `clks_per_bit(freq, baud)`.
  - Shared with `uart_monitor`.
- Sub-module `sync_fifo` (`WIDTH`, `DEPTH`): single clock, synchronous reset, registered read data, with push, pop, full, empty and count.
- The FSM, baud counter and shift register live in `uart_driver`.

## Test plan
- Reset check: hold `reset` for 5 cycles → `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0. `tx_valid`=1 during reset has no effect.
- Single byte: push 0x55 at E0 → `uart_tx`=0 at E1. The line then carries 0,1,0,1,0,1,0,1,0,1, each level held 434 cycles. `busy` drops at E1+4340. Loopback into `uart_monitor` decodes 0x55.
- Burst and full:
  - Hold `tx_valid` high with 0x00..0x10 (17 bytes) on consecutive edges → `tx_ready` low after the 17th accept and `fifo_count`=16.
  - An 18th byte held valid is not accepted until the first frame ends.
  - All frames are contiguous, taking 17 × 4340 cycles with no idle gap, and the monitor decodes them in order.
- Simultaneous push/pop: with `fifo_count`=3 and push on the STOP→START pop edge → `fifo_count` stays 3.
- Reset mid-frame: assert `reset` during data bit 3 of 0xFF → `uart_tx`=1 next edge, `fifo_count`=0, and no further frames. A following 0xA3 is transmitted and decoded correctly.
- Parameters: `CLK_FREQUENCY`=1_000_000, `BAUD_RATE`=100_000 → 10 cycles per bit and 100-cycle frames for 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the bench-side transmitter and monitor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; count is tracked separately
// from the modulo-DEPTH pointers so full and empty are unambiguous.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;
  assign o_data    = r_rd_data;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_driver.sv
// Buffered 8N1 UART transmitter: bytes pushed over valid/ready are queued in a
// FIFO and sent back to back on uart_tx at CLK_FREQUENCY / BAUD_RATE.
module uart_driver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB    = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned BAUD_W = (CPB < 2) ? 1 : $clog2(CPB);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  if (CPB < 2) begin : g_bad_baud
    $error("uart_driver: CLK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [BAUD_W-1:0]    r_baud;
  logic [BAUD_W-1:0]    w_baud_nxt;
  logic [BIT_W-1:0]     r_bit;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_pop;
  logic                 w_bit_done;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (tx_valid),
    .i_data    (tx_data),
    .i_pop     (w_pop),
    .o_data    (w_fifo_data),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty),
    .o_count   (fifo_count)
  );

  assign tx_ready   = !w_fifo_full;
  assign uart_tx    = r_tx;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;
  assign w_bit_done = (r_baud == BAUD_W'(CPB - 1));

  // The popped byte lands in the FIFO read register during the start bit,
  // so the shifter is loaded from it on the START -> DATA transition.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = IDLE_LEVEL;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = w_fifo_data[0];
          w_shift_nxt = {IDLE_LEVEL, w_fifo_data[DATA_BITS-1:1]};
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_W'(DATA_BITS - 1)) begin
            w_state_nxt = STOP;
            w_tx_nxt    = STOP_LEVEL;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {IDLE_LEVEL, r_shift[DATA_BITS-1:1]};
          end
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = IDLE_LEVEL;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule
